muldiv_seq: RTL and testbench

Sequencer for the HI/LO arithmetic resources used by the EX stage: the iterative divider (start/annul/ready handshake) and the fixed-latency multiplier. It accepts one mult/multu/div/divu operation, latches operands, and drives the selected unit. It raises the EX stall request until the result is ready, then issues exactly one HI/LO write when the instruction leaves EX. EX instantiates it in place of its open-coded divider control.

---
 rtl/muldiv_seq.sv | 214 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : muldiv_seq                                                    |
// | Purpose  : HI/LO sequencer for the EX stage. It drives the iterative     |
// |            divider and the fixed-latency multiplier, stalls EX, and      |
// |            issues one HI/LO write.                                       |
// | Options  : MULDIV_WDOG_EN adds a divider watchdog with a sticky error.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module muldiv_seq #(
   parameter int MUL_LAT     = 1,
   parameter int WDOG_CYCLES = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [1:0]  op_type,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        pipe_hold,
   input  logic        flush,
   input  logic        div_ready,
   input  logic [63:0] div_result,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_annul,
   output logic        div_signed,
   output logic [31:0] div_opdata1,
   output logic [31:0] div_opdata2,
   output logic        mul_signed,
   output logic [31:0] mul_ina,
   output logic [31:0] mul_inb,
   output logic        stallreq,
   output logic        hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata,
   output logic        busy,
   output logic        wdog_err
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MUL_WAIT = 2'd1,
      S_DIV_WAIT = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   localparam logic [2:0] c_mul_lat = 3'(MUL_LAT);

   state_t      r_state, w_state_nx;
   logic [31:0] r_a, r_b, r_hi, r_lo;
   logic [31:0] w_a_nx, w_b_nx, w_hi_nx, w_lo_nx;
   logic [1:0]  r_type, w_type_nx;
   logic [2:0]  r_cnt, w_cnt_nx;
   // Low while a stale div_ready from the previous divide is still visible.
   logic        r_go, w_go_nx;

`ifdef MULDIV_WDOG_EN
   localparam logic [5:0] c_wdog_lim = 6'(WDOG_CYCLES - 1);
   logic [5:0] r_wdog, w_wdog_nx;
   logic       r_err, w_err_nx;
`endif

   always_comb begin
      w_state_nx = r_state;
      w_a_nx     = r_a;
      w_b_nx     = r_b;
      w_type_nx  = r_type;
      w_cnt_nx   = r_cnt;
      w_hi_nx    = r_hi;
      w_lo_nx    = r_lo;
      w_go_nx    = r_go;
`ifdef MULDIV_WDOG_EN
      w_wdog_nx  = r_wdog;
      w_err_nx   = r_err;
`endif
      stallreq   = 1'b0;
      div_start  = 1'b0;
      div_annul  = 1'b0;
      div_signed = 1'b0;
      mul_signed = 1'b0;
      mul_ina    = '0;
      mul_inb    = '0;
      hilo_we    = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            stallreq = op_valid;
            if (op_valid && !flush) begin
               w_a_nx    = src_a;
               w_b_nx    = src_b;
               w_type_nx = op_type;
               if (!op_type[1]) begin
                  w_state_nx = S_MUL_WAIT;
                  w_cnt_nx   = c_mul_lat;
               end else if (src_b != 32'd0) begin
                  w_state_nx = S_DIV_WAIT;
                  w_go_nx    = !div_ready;
`ifdef MULDIV_WDOG_EN
                  w_wdog_nx  = '0;
`endif
               end else begin
                  // Divide by zero never reaches the divider.
                  w_state_nx = S_DONE;
                  w_hi_nx    = src_a;
                  w_lo_nx    = '1;
               end
            end
         end

         S_MUL_WAIT: begin
            stallreq   = 1'b1;
            mul_signed = !r_type[0];
            mul_ina    = r_a;
            mul_inb    = r_b;
            if (flush) begin
               w_state_nx = S_IDLE;
            end else if (r_cnt <= 3'd1) begin
               w_state_nx = S_DONE;
               w_hi_nx    = mul_result[63:32];
               w_lo_nx    = mul_result[31:0];
            end else begin
               w_cnt_nx = r_cnt - 3'd1;
            end
         end

         S_DIV_WAIT: begin
            stallreq   = 1'b1;
            div_signed = !r_type[0];
            if (flush) begin
               div_annul  = 1'b1;
               w_state_nx = S_IDLE;
            end else if (r_go && div_ready) begin
               w_state_nx = S_DONE;
               w_hi_nx    = div_result[63:32];
               w_lo_nx    = div_result[31:0];
`ifdef MULDIV_WDOG_EN
            end else if (r_wdog == c_wdog_lim) begin
               div_annul  = 1'b1;
               w_err_nx   = 1'b1;
               w_state_nx = S_DONE;
               w_hi_nx    = '0;
               w_lo_nx    = '0;
`endif
            end else begin
               div_start = r_go;
               if (!r_go) begin
                  w_go_nx = !div_ready;
               end
`ifdef MULDIV_WDOG_EN
               w_wdog_nx = r_wdog + 6'd1;
`endif
            end
         end

         S_DONE: begin
            if (flush) begin
               w_state_nx = S_IDLE;
            end else if (!pipe_hold) begin
               hilo_we    = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_type  <= '0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_go    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_a     <= w_a_nx;
         r_b     <= w_b_nx;
         r_type  <= w_type_nx;
         r_cnt   <= w_cnt_nx;
         r_hi    <= w_hi_nx;
         r_lo    <= w_lo_nx;
         r_go    <= w_go_nx;
      end
   end

`ifdef MULDIV_WDOG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         r_wdog <= w_wdog_nx;
         r_err  <= w_err_nx;
      end
   end

   assign wdog_err = r_err;
`else
   logic unused_wdog_cfg;
   assign unused_wdog_cfg = ^6'(WDOG_CYCLES);
   assign wdog_err        = 1'b0;
`endif

   assign div_opdata1 = r_a;
   assign div_opdata2 = r_b;
   assign hi_wdata    = r_hi;
   assign lo_wdata    = r_lo;
   assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_muldiv_seq                                                 |
// | Purpose  : Self-checking bench for muldiv_seq with divider/multiplier    |
// |            models and an arithmetic reference model.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_muldiv_seq;
   localparam int MUL_LAT     = 1;
   localparam int WDOG_CYCLES = 40;

   logic        clk = 1'b0;
   logic        rst, op_valid, pipe_hold, flush;
   logic [1:0]  op_type;
   logic [31:0] src_a, src_b;
   logic        div_ready;
   logic [63:0] div_result, mul_result;
   logic        div_start, div_annul, div_signed, mul_signed;
   logic [31:0] div_opdata1, div_opdata2, mul_ina, mul_inb;
   logic        stallreq, hilo_we, busy, wdog_err;
   logic [31:0] hi_wdata, lo_wdata;

   int n_checks = 0;
   int n_fail   = 0;
   int we_count = 0;
   int start_count = 0;
   int div_lat    = 33;
   int div_linger = 0;

   muldiv_seq #(.MUL_LAT(MUL_LAT), .WDOG_CYCLES(WDOG_CYCLES)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
      .src_a(src_a), .src_b(src_b), .pipe_hold(pipe_hold), .flush(flush),
      .div_ready(div_ready), .div_result(div_result), .mul_result(mul_result),
      .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
      .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
      .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
      .stallreq(stallreq), .hilo_we(hilo_we), .hi_wdata(hi_wdata),
      .lo_wdata(lo_wdata), .busy(busy), .wdog_err(wdog_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // {hi, lo} an instruction must write, from the ISA rules.
   function automatic logic [63:0] ref_model(input logic [1:0] t, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic signed [63:0] sp;
      sa = a;
      sb = b;
      case (t)
         2'b00: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp;
         end
         2'b01: return {32'b0, a} * {32'b0, b};
         default: begin
            if (b == 32'd0)   return {a, 32'hFFFF_FFFF};
            if (t == 2'b11)   return {a % b, a / b};
            return {32'(sa % sb), 32'(sa / sb)};
         end
      endcase
   endfunction

   assign mul_result = mul_signed
      ? $signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb})
      : {32'b0, mul_ina} * {32'b0, mul_inb};

   // Divider model: ready after div_lat start cycles, lingers div_linger cycles.
   int          dv_cnt, dv_lin;
   logic [63:0] dv_res;
   assign div_result = dv_res;

   always @(posedge clk) begin
      if (rst || div_annul) begin
         dv_cnt <= 0; dv_lin <= 0; div_ready <= 1'b0; dv_res <= '0;
      end else if (div_ready) begin
         if (!div_start) begin
            if (dv_lin >= div_linger) begin
               div_ready <= 1'b0;
               dv_cnt    <= 0;
            end else begin
               dv_lin <= dv_lin + 1;
            end
         end
      end else if (div_start) begin
         dv_cnt <= dv_cnt + 1;
         if (dv_cnt + 1 >= div_lat) begin
            div_ready <= 1'b1;
            dv_lin    <= 0;
            dv_res    <= ref_model({1'b1, ~div_signed}, div_opdata1, div_opdata2);
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         check_eq("start_while_ready", {63'b0, div_start & div_ready}, 64'd0);
         if (hilo_we)   we_count++;
         if (div_start) start_count++;
      end
   end

   // Runs one operation from an IDLE cycle through its HI/LO write.
   task automatic run_op(input string tag, input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input int exp_stall,
                         input int exp_starts);
      logic [63:0] exp;
      int stall_n, we0, st0;
      bit done;
      exp = ref_model(t, a, b);
      we0 = we_count;
      st0 = start_count;
      op_valid = 1'b1; op_type = t; src_a = a; src_b = b;
      pipe_hold = (hold > 0); flush = 1'b0;
      stall_n = 0; done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (stallreq) stall_n++; else done = 1'b1;
      end
      if (!done) begin
         check_eq({tag, "_timeout"}, 64'd1, 64'd0);
         op_valid = 1'b0; pipe_hold = 1'b0;
         return;
      end
      check_eq({tag, "_stall_len"}, 64'(stall_n), 64'(exp_stall));
      check_eq({tag, "_busy_done"}, {63'b0, busy}, 64'd1);
      for (int h = 0; h < hold; h++) begin
         check_eq({tag, "_we_in_hold"}, {63'b0, hilo_we}, 64'd0);
         @(posedge clk); #1;
         if (h == hold - 1) pipe_hold = 1'b0;
         @(negedge clk);
      end
      check_eq({tag, "_we"}, {63'b0, hilo_we}, 64'd1);
      check_eq({tag, "_hilo"}, {hi_wdata, lo_wdata}, exp);
      @(posedge clk); #1;
      op_valid = 1'b0;
      check_eq({tag, "_we_count"}, 64'(we_count - we0), 64'd1);
      check_eq({tag, "_start_cycles"}, 64'(start_count - st0), 64'(exp_starts));
   endtask

   initial begin
      logic [1:0]  t;
      logic [31:0] a, b;
      int          hold, we0, n;
      bit          seen;

      rst = 1'b1; op_valid = 1'b0; op_type = '0; src_a = '0; src_b = '0;
      pipe_hold = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ctrl", {58'b0, stallreq, busy, hilo_we, div_start, div_annul, wdog_err}, 64'd0);
      check_eq("rst_hilo", {hi_wdata, lo_wdata}, 64'd0);
      check_eq("rst_opnds", {div_opdata1, mul_ina}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, 0, 1 + MUL_LAT, 0);
      run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0, 2 + div_lat, div_lat);
      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 2 + div_lat, div_lat);
      run_op("div_by_zero", 2'b10, 32'h1234_5678, 32'd0, 0, 1, 0);
      run_op("mult_hold3", 2'b00, 32'd5, 32'd6, 3, 1 + MUL_LAT, 0);

      // Flush in the fifth DIV_WAIT cycle.
      div_lat = 100;
      we0 = we_count;
      op_valid = 1'b1; op_type = 2'b11; src_a = 32'd1000; src_b = 32'd3;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      flush = 1'b1; op_valid = 1'b0;
      @(negedge clk);
      check_eq("flush_annul", {62'b0, div_annul, div_start}, 64'd2);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check_eq("flush_idle", {62'b0, busy, stallreq}, 64'd0);
      check_eq("flush_no_we", 64'(we_count - we0), 64'd0);
      @(posedge clk); #1;
      div_lat = 33;
      run_op("multu_after_flush", 2'b01, 32'hFFFF_FFFF, 32'd2, 0, 1 + MUL_LAT, 0);

      // Flush in IDLE blocks acceptance.
      op_valid = 1'b1; flush = 1'b1; op_type = 2'b00; src_a = 32'd9; src_b = 32'd9;
      @(negedge clk);
      check_eq("idle_flush_stall", {63'b0, stallreq}, 64'd1);
      @(posedge clk); #1;
      op_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check_eq("idle_flush_busy", {63'b0, busy}, 64'd0);
      @(posedge clk); #1;

      // Lingering div_ready delays div_start of the back-to-back divide.
      div_linger = 2;
      run_op("divu_linger_a", 2'b11, 32'd100, 32'd7, 0, 2 + div_lat, div_lat);
      run_op("divu_linger_b", 2'b11, 32'd50, 32'd5, 0, 3 + div_lat, div_lat);
      div_linger = 0;
      run_op("mult_b2b", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1 + MUL_LAT, 0);

      for (int k = 0; k < 24; k++) begin
         t = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         if (t == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
         div_lat = $urandom_range(1, 12);
         hold    = $urandom_range(0, 2);
         if (!t[1])            run_op("rnd_mul", t, a, b, hold, 1 + MUL_LAT, 0);
         else if (b == 32'd0)  run_op("rnd_div0", t, a, b, hold, 1, 0);
         else                  run_op("rnd_div", t, a, b, hold, 2 + div_lat, div_lat);
      end

`ifdef MULDIV_WDOG_EN
      div_lat = 10000;
      op_valid = 1'b1; op_type = 2'b11; src_a = 32'd77; src_b = 32'd5;
      @(posedge clk); #1;
      seen = 1'b0; n = 0;
      for (int i = 1; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (div_annul) begin seen = 1'b1; n = i; end
      end
      check_eq("wdog_annul_cycle", 64'(n), 64'(WDOG_CYCLES));
      @(negedge clk);
      check_eq("wdog_done", {61'b0, wdog_err, stallreq, hilo_we}, 64'd5);
      check_eq("wdog_hilo", {hi_wdata, lo_wdata}, 64'd0);
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      check_eq("wdog_sticky", {62'b0, wdog_err, busy}, 64'd2);
      div_lat = 33;
`else
      seen = 1'b0; n = 0;
`endif

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
`default_nettype wire
